// File: rtl/interboard_tx.sv
// Board-to-board transmit stage: captures a one-cycle message request and delivers it
// over a four-phase req/ack link with a synchronized ack, timeout, overrun and parity.
module interboard_tx #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  input  logic       transmit,
  input  logic       tx_ack,
  output logic       tx_req,
  output logic [7:0] tx_data,
  output logic       tx_parity,
  output logic       inter_ready,
  output logic       busy,
  output logic       tx_timeout,
  output logic       overrun
);

  localparam logic [15:0] SetupLast = 16'(SETUP_CYC - 1);
  localparam logic [15:0] ToLast    = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StReqHi, StReqLo, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        ack_meta_q, ack_s_q;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        req_q, req_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        to_q, to_d;
  logic        ov_q, ov_d;

  // Next-state, counter, capture and sticky-flag logic; outputs follow the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    par_d   = par_q;
    to_d    = to_q;
    ov_d    = ov_q;
    // Saturating increment so a stuck phase can never wrap back past the limit
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ctrl_en) begin
          data_d  = {ctrl_msg_type, ctrl_number};
          par_d   = ^{ctrl_msg_type, ctrl_number};
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StReqHi;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StReqHi: begin
        if (ack_s_q) begin
          cnt_d   = '0;
          state_d = StReqLo;
        end else if (cnt_q == ToLast) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StReqLo: begin
        if (!ack_s_q) begin
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q == ToLast) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // The DONE cycle counts as busy, so a request there is dropped too
    if (ctrl_en && (state_q != StIdle) && transmit) begin
      ov_d = 1'b1;
    end

    req_d   = (state_d == StReqHi);
    ready_d = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // State, ack synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      data_q     <= '0;
      par_q      <= 1'b0;
      req_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_meta_q <= tx_ack;
      ack_s_q    <= ack_meta_q;
      data_q     <= data_d;
      par_q      <= par_d;
      req_q      <= req_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      to_q       <= to_d;
      ov_q       <= ov_d;
    end
  end

  assign tx_req      = req_q;
  assign tx_data     = data_q;
  assign tx_parity   = par_q;
  assign inter_ready = ready_q;
  assign busy        = busy_q;
  assign tx_timeout  = to_q;
  assign overrun     = ov_q;

endmodule

// File: doc/interboard_tx.md
Name: interboard_tx

Overview:
- Downstream transmit stage of the game controller (master or slave).
- Captures a one-cycle message request (ctrl_en with msg_type and number) and drives it across the board-to-board link using a four-phase req/ack handshake with a synchronized ack.
- Returns a one-cycle inter_ready pulse once the remote board has fully acknowledged; the game FSM advances on that pulse.
- Provides a timeout, an overrun flag and a parity bit for link robustness.

Parameters:
- SETUP_CYC, 2: cycles tx_data is held stable before tx_req rises (1..15).
- TIMEOUT_CYC, 50000: max cycles spent waiting in either ack phase before abort (counter width 16).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ctrl_en  input  1  one-cycle request to send a message
- ctrl_msg_type  input  3  message type, sampled when ctrl_en=1
- ctrl_number  input  5  number payload, sampled when ctrl_en=1
- transmit  input  1  game FSM is in a sending state; used only for overrun qualification
- tx_ack  input  1  asynchronous ack from remote board
- tx_req  output  1  request to remote board
- tx_data  output  8  {msg_type[2:0], number[4:0]}
- tx_parity  output  1  even parity over tx_data (XOR of all 8 bits)
- inter_ready  output  1  one-cycle pulse: message delivered
- busy  output  1  high in every state except IDLE
- tx_timeout  output  1  sticky: an ack phase timed out
- overrun  output  1  sticky: ctrl_en arrived while busy

Behaviour:
- Reset: all outputs 0. tx_data=0, tx_parity=0, state=IDLE, counters=0, ack synchronizer=00. Reset mid-handshake drops tx_req the next edge without waiting for ack.
- tx_ack passes through a 2-FF synchronizer (ack_s). All decisions use ack_s, so ack-edge-to-reaction latency is 2 cycles.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO, DONE.
- IDLE: on ctrl_en, latch tx_data={ctrl_msg_type,ctrl_number}, latch parity, clear cnt, go to SETUP. tx_data is valid from cycle T+1, where T is the ctrl_en cycle.
- SETUP: cnt increments each cycle. When cnt==SETUP_CYC-1, go to REQ_HI and clear cnt. tx_req=1 from cycle T+1+SETUP_CYC.
- REQ_HI: tx_req=1. When ack_s==1, go to REQ_LO and clear cnt. If cnt reaches TIMEOUT_CYC-1 first, set tx_timeout and go to IDLE; tx_req falls, no inter_ready.
- REQ_LO: tx_req=0, tx_data held. When ack_s==0, go to DONE. A timeout here behaves the same as in REQ_HI (set tx_timeout, go to IDLE).
- DONE: inter_ready=1 for exactly this cycle, then go to IDLE. tx_data keeps its last value until the next capture.
- busy=1 in SETUP, REQ_HI, REQ_LO, DONE.
- ctrl_en while busy: request ignored, latched data unchanged, overrun set if transmit=1. Only rst clears overrun and tx_timeout.
- ctrl_en in the same cycle as DONE: treated as busy (ignored). The earliest accepted new request is the cycle after DONE.
- ack_s already 1 when entering REQ_HI (stale ack): REQ_HI exits next cycle, then REQ_LO waits for ack_s to fall. No spurious inter_ready before the full handshake completes.
- Timeout counter saturates and never wraps. Comparison is equality against TIMEOUT_CYC-1.
- Minimum delivery time, ack responding instantly: 1 + SETUP_CYC + 2 (sync rise) + 2 (sync fall) + 1 (DONE), i.e. inter_ready at T+SETUP_CYC+6 for SETUP_CYC=2 → T+8 (within ±1 for remote ack turnaround).

Test Plan:
- Basic send: ctrl_en with msg_type=3'd2, number=5'd17 → tx_data=8'h51, tx_parity=1. tx_req rises at T+3. Remote acks 4 cycles after req and drops ack 4 cycles after req falls. inter_ready pulses exactly once; busy falls the cycle after.
- Back-to-back: second ctrl_en (type 3, number 9) in the DONE cycle → ignored, overrun=1 with transmit=1, tx_data stays 8'h51. Reissued one cycle later → accepted, tx_data=8'h69, parity=0.
- Timeout: ack never asserted, TIMEOUT_CYC=16 → tx_req drops after 16 cycles in REQ_HI, tx_timeout=1 sticky, no inter_ready, busy=0. A subsequent send completes normally with tx_timeout still 1.
- Stale ack: tx_ack held 1 before ctrl_en → FSM passes REQ_HI quickly, waits in REQ_LO. Release ack → inter_ready 3 cycles later.
- Reset mid-handshake: rst asserted in REQ_HI → next cycle tx_req=0, busy=0, tx_data=0, flags cleared. A subsequent send works.
- Metastability/glitch: a 1-cycle tx_ack glitch while in SETUP has no effect on state.
